gearbox_64_48: RTL and testbench

// - Reverse gearbox of the PCS 48->64 path: takes 64-bit words (4 x 16-bit lanes) from the upper side and emits 48-bit words (3 x 16-bit lanes) downstream.
// - Lane order is preserved: lane 0 = bits [15:0] goes out first; no lane is dropped, duplicated or reordered.
// - Sits between the 64-bit PCS datapath and the 48-bit serializer side; both sides use the codebase idle/valid handshake.

---
 rtl/gearbox_64_48.sv | 79 +++++++
 tb/tb_gearbox_64_48.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_64_48.sv
// rtl/gearbox_64_48.sv - 64-bit to 48-bit lane gearbox (4 lanes in, 3 lanes out)
// Optional sticky overflow flag enabled by defining GEARBOX_64_48_OVF_EN.
module gearbox_64_48 #(
  parameter int LANE_W = 16,
  parameter int BUF_LN = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_enable,
  output logic                  out_idle,
  input  logic [4*LANE_W-1:0]   in_data,
  input  logic                  in_datavalid,
  output logic                  empty_save,
  output logic [3*LANE_W-1:0]   out_data,
  output logic                  out_datavalid,
  input  logic                  in_idle,
  output logic                  ovf_err
);

  localparam int BUF_W = BUF_LN * LANE_W;

  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic             push;
  logic             pop;
  logic [1:0]       base;

  assign out_idle      = (cnt_q <= 3'd3);
  assign out_datavalid = in_enable && (cnt_q >= 3'd3);
  assign out_data      = buf_q[3*LANE_W-1:0];
  assign empty_save    = (cnt_q == 3'd0) || (cnt_q == 3'd3) || (cnt_q == 3'd6);

  assign pop  = out_datavalid && in_idle;
  assign push = in_enable && in_datavalid && out_idle;

  // A push only happens with cnt <= 3, and a simultaneous pop implies cnt == 3,
  // so the write base always fits in two bits and the 4-lane write stays in range.
  always_comb begin
    buf_d = buf_q;
    base  = cnt_q[1:0];
    if (pop) begin
      buf_d = {{(3*LANE_W){1'b0}}, buf_q[BUF_W-1:3*LANE_W]};
      base  = 2'd0;
    end
    if (push) begin
      buf_d[LANE_W*base +: 4*LANE_W] = in_data;
    end
    cnt_d = cnt_q + (push ? 3'd4 : 3'd0) - (pop ? 3'd3 : 3'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 3'd0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

`ifdef GEARBOX_64_48_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (in_enable && in_datavalid && !out_idle) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_64_48.sv
// tb/tb_gearbox_64_48.sv - scoreboard bench for gearbox_64_48
module tb_gearbox_64_48;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_enable;
  logic        out_idle;
  logic [63:0] in_data;
  logic        in_datavalid;
  logic        empty_save;
  logic [47:0] out_data;
  logic        out_datavalid;
  logic        in_idle;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [15:0] lane_q[$];
  logic [47:0] exp_q[$];
  int          mcnt = 0;
  logic        movf = 1'b0;
  logic        last_acc;

  gearbox_64_48 dut (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .out_idle(out_idle),
    .in_data(in_data), .in_datavalid(in_datavalid), .empty_save(empty_save),
    .out_data(out_data), .out_datavalid(out_datavalid), .in_idle(in_idle),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completed downstream transfer is popped and compared in order.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_datavalid === 1'b1 && in_idle === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {16'h0, out_data}, 64'hDEAD);
      end else begin
        chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic idle, input logic en);
    logic mpush;
    logic mpop;
    in_datavalid = v;
    in_data      = d;
    in_idle      = idle;
    in_enable    = en;
    @(negedge clk);
    chk("out_idle", {63'h0, out_idle}, {63'h0, mcnt <= 3});
    chk("out_datavalid", {63'h0, out_datavalid}, {63'h0, en && (mcnt >= 3)});
    chk("empty_save", {63'h0, empty_save}, {63'h0, mcnt == 0 || mcnt == 3 || mcnt == 6});
    chk("ovf_err", {63'h0, ovf_err}, {63'h0, movf});
    mpush = en && v && (mcnt <= 3);
    mpop  = en && idle && (mcnt >= 3);
    @(posedge clk);
`ifdef GEARBOX_64_48_OVF_EN
    if (en && v && mcnt > 3) movf = 1'b1;
`endif
    if (mpush) begin
      for (int i = 0; i < 4; i++) lane_q.push_back(d[16*i +: 16]);
      while (lane_q.size() >= 3) begin
        exp_q.push_back({lane_q[2], lane_q[1], lane_q[0]});
        void'(lane_q.pop_front());
        void'(lane_q.pop_front());
        void'(lane_q.pop_front());
      end
    end
    mcnt = mcnt + (mpush ? 4 : 0) - (mpop ? 3 : 0);
    last_acc = mpush;
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic idle);
    logic acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      step(1'b1, d, idle, 1'b1);
      acc = last_acc;
    end
    if (!acc) chk("send_timeout", 64'h0, 64'h1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_datavalid", {63'h0, out_datavalid}, 64'h0);
    chk("rst_out_idle", {63'h0, out_idle}, 64'h1);
    chk("rst_empty_save", {63'h0, empty_save}, 64'h1);
    chk("rst_out_data", {16'h0, out_data}, 64'h0);
    chk("rst_ovf_err", {63'h0, ovf_err}, 64'h0);
    lane_q.delete();
    exp_q.delete();
    mcnt = 0;
    movf = 1'b0;
    in_datavalid = 1'b0;
    in_idle      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [15:0] ln;
    reset_n = 1'b0; in_enable = 1'b1; in_data = '0; in_datavalid = 1'b0; in_idle = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single word, then no further valid
    send(64'h4444_3333_2222_1111, 1'b1);
    chk("single_first", {16'h0, exp_q[0]}, 64'h3333_2222_1111);
    n0 = n_out;
    repeat (4) step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("single_count", n_out - n0, 1);
    chk("single_cnt1", mcnt, 1);

    // Stream: 12 words at 3 per 4 cycles, 16 outputs
    do_reset();
    ln = 16'h0001;
    n0 = n_out;
    for (int w = 0; w < 12; w++) begin
      send({ln + 16'd3, ln + 16'd2, ln + 16'd1, ln}, 1'b1);
      ln = ln + 16'd4;
      if (w % 3 == 2) step(1'b0, 64'h0, 1'b1, 1'b1);
    end
    repeat (6) step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("stream_count", n_out - n0, 16);

    // Backpressure: second push blocked at cnt=4
    step(1'b1, 64'h0D0C_0B0A_0908_0706, 1'b0, 1'b1);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    chk("bp_blocked", {63'h0, last_acc}, 64'h0);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    chk("bp_cnt4", mcnt, 4);
    repeat (2) step(1'b0, 64'h0, 1'b1, 1'b1);

    // Full: reach cnt=3 then push to 7, drain 7->4->1
    do_reset();
    ln = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, {ln + 16'd3, ln + 16'd2, ln + 16'd1, ln}, 1'b0, 1'b1);
      ln = ln + 16'd4;
      step(1'b0, 64'h0, 1'b1, 1'b1);
    end
    chk("full_cnt3", mcnt, 3);
    step(1'b1, {ln + 16'd3, ln + 16'd2, ln + 16'd1, ln}, 1'b0, 1'b1);
    chk("full_cnt7", mcnt, 7);
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("full_cnt1", mcnt, 1);

    // Enable low for 5 cycles at cnt=4
    do_reset();
    step(1'b1, 64'hA004_A003_A002_A001, 1'b0, 1'b1);
    n0 = n_out;
    repeat (5) step(1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 1'b1, 1'b0);
    chk("en_frozen_out", n_out - n0, 0);
    step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("en_resume_out", n_out - n0, 1);

    // Overflow attempt at cnt=4
    do_reset();
    step(1'b1, 64'hC004_C003_C002_C001, 1'b0, 1'b1);
    step(1'b1, 64'hC008_C007_C006_C005, 1'b0, 1'b1);
    repeat (2) step(1'b0, 64'h0, 1'b0, 1'b1);

    // Reset mid-stream at cnt=5, then no stale lane
    step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'hC008_C007_C006_C005, 1'b0, 1'b1);
    chk("mid_cnt5", mcnt, 5);
    do_reset();
    n0 = n_out;
    send(64'hE004_E003_E002_E001, 1'b1);
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b1);
    chk("post_reset_count", n_out - n0, 1);
    chk("exp_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
